// File: rtl/alu_iter.sv
// Iterative RV32I integer ALU: one request at a time, valid/ready handshake on both sides.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts go one bit per cycle.
module alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            op_imm,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] res1,
  output logic            eq,
  output logic            ge,
  output logic            less,
  output logic            ge_u,
  output logic            less_u
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [2:0]      f3_q;
  logic            alt_q;
  logic            imm_q;
  logic [4:0]      cnt;
  logic [4:0]      cnt_load;
  logic            accept;
  logic            finish;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] result;
  logic            unused_f7;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = (state == IDLE) && req_valid;
  assign finish    = (state == BUSY) && (cnt == '0);
  assign lt_s      = $signed(a_q) < $signed(b_q);
  assign lt_u      = a_q < b_q;
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

`ifdef ALU_FAST_SHIFT_EN
  logic signed [XLEN-1:0] sra_fast;
  logic        [XLEN-1:0] shift_res;

  // Arithmetic shift kept in its own signed net so the ternary's unsigned context cannot turn it logical
  assign sra_fast  = $signed(a_q) >>> b_q[4:0];
  assign shift_res = f3_q[2] ? (alt_q ? sra_fast : (a_q >> b_q[4:0])) : (a_q << b_q[4:0]);
  assign cnt_load  = '0;
`else
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] shift_res;

  assign shift_res = work;
  assign cnt_load  = (funct3[1:0] == 2'b01) ? b[4:0] : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid)   state_nxt = BUSY;
      BUSY:    if (cnt == '0)   state_nxt = DONE;
      DONE:    if (rsp_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      alt_q <= 1'b0;
      imm_q <= 1'b0;
      cnt   <= '0;
`ifndef ALU_FAST_SHIFT_EN
      work  <= '0;
`endif
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      f3_q  <= funct3;
      alt_q <= funct7[5];
      imm_q <= op_imm;
      cnt   <= cnt_load;
`ifndef ALU_FAST_SHIFT_EN
      work  <= a;
    end else if ((state == BUSY) && (cnt != '0)) begin
      // funct3[2] separates right shifts (101) from the left shift (001)
      cnt  <= cnt - 5'd1;
      work <= f3_q[2] ? {alt_q & work[XLEN-1], work[XLEN-1:1]} : {work[XLEN-2:0], 1'b0};
`endif
    end
  end

  always_comb begin
    result = '0;
    unique case (f3_q)
      3'b000:         result = (alt_q && !imm_q) ? (a_q - b_q) : (a_q + b_q);
      3'b001, 3'b101: result = shift_res;
      3'b010:         result = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:         result = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:         result = a_q ^ b_q;
      3'b110:         result = a_q | b_q;
      3'b111:         result = a_q & b_q;
      default:        result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res1   <= '0;
      eq     <= 1'b0;
      ge     <= 1'b0;
      less   <= 1'b0;
      ge_u   <= 1'b0;
      less_u <= 1'b0;
    end else if (finish) begin
      res1   <= result;
      eq     <= (a_q == b_q);
      ge     <= !lt_s;
      less   <= lt_s;
      ge_u   <= !lt_u;
      less_u <= lt_u;
    end
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have ports a, b  input  XLEN  operands (b[4:0] is the shift amount).
REQ-007 SHALL have ports funct3  input  3, funct7  input  7, op_imm  input  1  RV32I operation select.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have port res1  output  XLEN  registered result.
REQ-011 SHALL have ports eq, ge, less, ge_u, less_u  output  1 each  registered compare flags of a vs b.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE; req_ready = (state==IDLE); rsp_valid = (state==DONE).
REQ-013 SHALL in IDLE, on req_valid, capture a, b, funct3, funct7, op_imm and go to BUSY with cnt = b[4:0] for funct3 001/101, else cnt = 0.
REQ-014 SHALL decode: 000 add (sub when funct7[5]=1 and op_imm=0), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra when funct7[5]=1), 110 or, 111 and; slt/sltu yield 0 or 1 in res1.
REQ-015 SHALL ignore funct7[5] for 000 when op_imm=1, and for all funct3 other than 000/101.
REQ-016 SHALL in BUSY, when cnt!=0, shift the working value by exactly one bit (sra replicates bit 31) and decrement cnt.
REQ-017 SHALL in BUSY, when cnt==0, register res1 and all five flags and go to DONE.
REQ-018 SHALL give latency (accept edge to rsp_valid high) of 1 cycle for non-shifts and for shamt 0, and 1+shamt cycles for shifts.
REQ-019 SHALL hold res1 and flags stable in DONE until rsp_ready is sampled high, then return to IDLE; no request is accepted in the same cycle.
REQ-020 SHALL keep res1 and flags at their last values while in IDLE and BUSY.
REQ-021 SHALL compute flags on captured operands: eq = a==b; less/ge signed; less_u/ge_u unsigned; ge = !less, ge_u = !less_u.
REQ-022 SHALL wrap add/sub modulo 2^32 with no overflow indication.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-shift, asynchronously force state IDLE, cnt 0, res1 0, all flags 0, rsp_valid 0.
REQ-024 SHALL assert req_ready in the first cycle after rst_n deasserts; an in-flight operation is discarded, not completed.

Configuration
REQ-025 SHALL honour macro ALU_FAST_SHIFT_EN: when defined, shifts use a single-cycle barrel shifter, cnt is always 0, and every operation has latency 1.
REQ-026 SHALL, without ALU_FAST_SHIFT_EN, use the one-bit-per-cycle serial shifter of REQ-016; results are bit-identical in both builds.

Verification
REQ-027 SHALL cover a=20, b=7, all ten ops with rsp_ready=1 -> res1 = 27, 13, 2560, 0, 0, 19, 0, 0, 23, 4; eq=0, ge=1, ge_u=1; sll rsp_valid 8 cycles after accept (1 with ALU_FAST_SHIFT_EN).
REQ-028 SHALL cover a=-100 (0xFFFFFF9C), b=4 -> add 0xFFFFFFA0, sub 0xFFFFFF98, sll 0xFFFFF9C0, slt 1, sltu 0, srl 0x0FFFFFF9, sra 0xFFFFFFF9; less=1, ge_u=1.
REQ-029 SHALL cover a=10000000, b=-10000000 -> add 0, sub 20000000, slt 0, sltu 1, sll 10000000 with latency 1 (b[4:0]=0); ge=1, less_u=1.
REQ-030 SHALL cover backpressure: rsp_ready low 5 cycles in DONE -> rsp_valid, res1, flags unchanged, req_ready low throughout; IDLE one cycle after rsp_ready high.
REQ-031 SHALL cover rst_n pulsed low during an sra with shamt 31 -> outputs zero immediately, req_ready high after release, next request a=20, b=7, add returns 27.
REQ-032 SHALL cover op_imm=1, funct3=000, funct7=0100000, a=20, b=7 -> res1 = 27.
